spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
- REQ-001: Parameter SYNC_STAGES, default 2. Number of synchronizer flops on sclk, mosi and cs_n. Legal values are 2 and 3.
- REQ-002: One clock and one reset. Reset is asynchronous and active-high.
- REQ-003: clk  in  1  system clock; all logic on rising edge.
- REQ-004: rst  in  1  asynchronous reset, active-high.
- REQ-005: sclk  in  1  SPI clock from master, asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
- REQ-006: mosi  in  1  serial data from master, asynchronous.
- REQ-007: cs_n  in  1  chip select, active-low, asynchronous.
- REQ-008: miso  out  1  serial data to master.
- REQ-009: spi_byte_out  in  8  byte to transmit; supplied by the data transfer controller.
- REQ-010: spi_byte_in  out  8  last complete byte received.
- REQ-011: spi_cycle_done  out  1  one-clk pulse; a full byte was exchanged.
- REQ-012: spi_abort  out  1  one-clk pulse; cs_n rose with a partial byte pending.
- REQ-013: frame_active  out  1  high while synchronized cs_n is low.

Function
- REQ-014: sclk, mosi and cs_n shall each pass through SYNC_STAGES flops, followed by one history flop per signal for edge detection. Edges are taken from the last sync stage only.
- REQ-015: Clock ratio constraint: f_clk >= 8 x f_sclk, and every sclk high or low phase >= SYNC_STAGES+2 clk periods.
- REQ-016: Edges of synchronized sclk shall be ignored while synchronized cs_n is high.
- REQ-017: On each sclk rising edge in a frame, rx_shift <= {rx_shift[6:0], mosi_sync} (MSB first) and bit_cnt (3 bits) shall increment.
- REQ-018: On the rising edge where bit_cnt==7, the block shall:
  - register spi_byte_in <= {rx_shift[6:0], mosi_sync};
  - assert spi_cycle_done for exactly one clk;
  - wrap bit_cnt to 0.
- REQ-019: Latency: spi_cycle_done and the new spi_byte_in shall be visible after clk edge SYNC_STAGES+1, counting as edge 1 the first clk edge that samples raw sclk high on the 8th bit.
- REQ-020: spi_byte_in shall hold its value until the next completed byte or reset.
- REQ-021: tx_shift shall load spi_byte_out when either:
  - synchronized cs_n falls; or
  - the first sclk falling edge after a byte completes (bit_cnt==0).
- REQ-022: On every other in-frame sclk falling edge, tx_shift shall shift left by one.
- REQ-023: miso = tx_shift[7] while frame_active; miso = 0 while cs_n is high.
- REQ-024: A spi_byte_out value written by the controller in the clk after spi_cycle_done shall be the byte transmitted in the next byte slot. REQ-015 guarantees that timing.
- REQ-025: When synchronized cs_n rises with bit_cnt != 0:
  - discard the partial byte;
  - reset bit_cnt to 0;
  - pulse spi_abort for one clk;
  - do not pulse spi_cycle_done;
  - leave spi_byte_in unchanged.
- REQ-026: When synchronized cs_n rises with bit_cnt == 0, bit_cnt shall reset with no pulse.
- REQ-027: If a cs_n rise and the 8th sclk rise are detected in the same clk, the byte shall complete (spi_cycle_done pulses) and spi_abort shall not pulse.
- REQ-028: Back-to-back bytes within one frame shall need no gap; bit_cnt alignment continues across bytes.
- REQ-029: spi_cycle_done and spi_abort shall never both be high in the same clk.

Reset
- REQ-030: While rst is high, the following shall be 0: spi_byte_in, spi_cycle_done, spi_abort, frame_active, miso, rx_shift, tx_shift, bit_cnt.
- REQ-031: While rst is high, the sclk and mosi sync/history flops shall be 0, and the cs_n sync/history flops shall be 1 (inactive).
- REQ-032: Reset asserted mid-byte shall abandon the byte with no spi_cycle_done or spi_abort pulse.
- REQ-033: After reset releases, the first byte shall be received only after a fresh cs_n fall.

Verification
- REQ-034: rst pulse with cs_n=1 -> all outputs 0; no pulses while sclk toggles with cs_n high.
- REQ-035: Master sends 0xA5 (SYNC_STAGES=2, clk = 16 x sclk) -> spi_cycle_done one clk wide, 3 clk after the 8th raw sclk rise; spi_byte_in=0xA5.
- REQ-036: spi_byte_out=0x3C before cs_n falls while master sends 0x00 -> master samples 0x3C on miso; spi_byte_in=0x00.
- REQ-037: Same frame carries 0x12 then 0x34; bench drives spi_byte_out=0x56 in the clk after the first done -> two done pulses with spi_byte_in 0x12 then 0x34; miso byte 2 = 0x56.
- REQ-038: cs_n raised after 5 bits of 0xFF, then new frame sends 0x81 -> one spi_abort pulse, no done for the partial byte; next done gives spi_byte_in=0x81.
- REQ-039: rst asserted after 4 bits, released, new frame sends 0x7E -> no pulse during reset; spi_byte_in=0x7E after the next done.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI byte slave; sclk/mosi/cs_n are synchronized into clk and
// each completed byte or aborted partial byte is reported with a one-clk pulse.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    output logic       miso,
    input  logic [7:0] spi_byte_out,
    output logic [7:0] spi_byte_in,
    output logic       spi_cycle_done,
    output logic       spi_abort,
    output logic       frame_active
);
    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
    logic       sclk_h_q, cs_h_q;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, byte_q, byte_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       done_q, abort_q;
    logic       sclk_s, mosi_s, cs_s, in_frame, rise, fall, cs_fall, cs_rise, last;

    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign cs_s    = cs_q[SYNC_STAGES-1];
    // The clk in which cs_n rises still counts as in-frame so a coincident 8th edge completes.
    assign in_frame = ~cs_s | ~cs_h_q;
    assign rise     = in_frame & sclk_s & ~sclk_h_q;
    assign fall     = in_frame & ~sclk_s & sclk_h_q;
    assign cs_fall  = ~cs_s & cs_h_q;
    assign cs_rise  = cs_s & ~cs_h_q;
    assign last     = rise & (bit_cnt_q == 3'd7);

    always_comb begin
        rx_d      = rise ? {rx_q[6:0], mosi_s} : rx_q;
        bit_cnt_d = (cs_rise & ~last) ? 3'd0 : rise ? bit_cnt_q + 3'd1 : bit_cnt_q;
        byte_d    = last ? {rx_q[6:0], mosi_s} : byte_q;
        tx_d      = (cs_fall | (fall & bit_cnt_q == 3'd0)) ? spi_byte_out :
                    fall ? {tx_q[6:0], 1'b0} : tx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q    <= '0;
            mosi_q    <= '0;
            cs_q      <= '1;
            sclk_h_q  <= 1'b0;
            cs_h_q    <= 1'b1;
            rx_q      <= '0;
            tx_q      <= '0;
            byte_q    <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
            cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_n};
            sclk_h_q  <= sclk_s;
            cs_h_q    <= cs_s;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            byte_q    <= byte_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= last;
            abort_q   <= cs_rise & ~last & (bit_cnt_q != 3'd0);
        end
    end

    assign frame_active   = ~cs_s;
    assign miso           = frame_active & tx_q[7];
    assign spi_byte_in    = byte_q;
    assign spi_cycle_done = done_q;
    assign spi_abort      = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives an SPI master model against spi_slave; received bytes are
// scoreboarded through a queue popped on each spi_cycle_done.
module tb_spi_slave;
    logic       clk = 0, rst = 0, sclk = 0, mosi = 0, cs_n = 1;
    logic [7:0] spi_byte_out = 8'h00;
    logic       miso, spi_cycle_done, spi_abort, frame_active;
    logic [7:0] spi_byte_in;

    int   checks = 0, errors = 0, done_cnt = 0, abort_cnt = 0;
    time  done_t = 0, rise_t = 0;
    logic prev_done = 0;
    logic [7:0] exp_q[$];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
        .spi_byte_out(spi_byte_out), .spi_byte_in(spi_byte_in),
        .spi_cycle_done(spi_cycle_done), .spi_abort(spi_abort), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (spi_cycle_done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: spi_cycle_done high 2+ clks, required 1");
            end else begin
                done_cnt++;
                done_t = $time;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: done with byte_in=%h, no byte expected", spi_byte_in);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (spi_byte_in !== e) begin
                        errors++;
                        $display("FAIL sb_byte: byte_in=%h required %h", spi_byte_in, e);
                    end
                end
            end
        end
        if (spi_abort) abort_cnt++;
        if (spi_cycle_done || spi_abort) begin
            checks++;
            if (spi_cycle_done && spi_abort) begin
                errors++;
                $display("FAIL excl: done=1 abort=1 together, required not both");
            end
        end
        prev_done = spi_cycle_done;
    end

    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] m);
        m = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            #80;
            m[i] = miso;
            sclk = 1;
            rise_t = $time;
            #80;
            sclk = 0;
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        #20;
        checks++;
        if ({spi_byte_in, spi_cycle_done, spi_abort, frame_active, miso} !== 12'h000) begin
            errors++;
            $display("FAIL reset_out: got %h required 000",
                     {spi_byte_in, spi_cycle_done, spi_abort, frame_active, miso});
        end
        rst = 0;
        #20;
        for (int i = 0; i < 8; i++) begin
            mosi = 1'($urandom_range(1));
            #80 sclk = 1;
            #80 sclk = 0;
        end
        #80;
        checks++;
        if (done_cnt !== 0 || abort_cnt !== 0 || miso !== 1'b0 || frame_active !== 1'b0) begin
            errors++;
            $display("FAIL idle_pulses: done=%0d abort=%0d miso=%b fa=%b required 0 0 0 0",
                     done_cnt, abort_cnt, miso, frame_active);
        end
        chk8("idle_byte_in", spi_byte_in, 8'h00);
    endtask

    task automatic test_basic;
        logic [7:0] m;
        int d0;
        d0 = done_cnt;
        spi_byte_out = 8'hFF;
        cs_n = 0;
        #80;
        exp_q.push_back(8'hA5);
        xfer(8'hA5, 8, m);
        #80 cs_n = 1;
        #240;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL basic_done_cnt: got %0d required %0d", done_cnt - d0, 1);
        end
        checks++;
        if (done_t - rise_t !== 30) begin
            errors++;
            $display("FAIL basic_latency: done %0t after 8th rise, required 30", done_t - rise_t);
        end
        chk8("basic_byte_in", spi_byte_in, 8'hA5);
        chk8("basic_miso", m, 8'hFF);
        chk8("basic_idle_fa_miso", {6'd0, frame_active, miso}, 8'h00);
    endtask

    task automatic test_miso;
        logic [7:0] m;
        spi_byte_out = 8'h3C;
        cs_n = 0;
        #80;
        chk8("miso_frame_active", {7'd0, frame_active}, 8'h01);
        exp_q.push_back(8'h00);
        xfer(8'h00, 8, m);
        #80 cs_n = 1;
        #240;
        chk8("miso_byte", m, 8'h3C);
        chk8("miso_byte_in", spi_byte_in, 8'h00);
    endtask

    task automatic test_back_to_back;
        logic [7:0] m1, m2;
        int d0;
        d0 = done_cnt;
        spi_byte_out = 8'h9A;
        cs_n = 0;
        #80;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        fork
            begin
                xfer(8'h12, 8, m1);
                xfer(8'h34, 8, m2);
            end
            begin
                logic seen;
                seen = 0;
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge clk);
                    seen = spi_cycle_done;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL b2b_timeout: no done within 2000 clks, required one");
                end else begin
                    @(negedge clk);
                    spi_byte_out = 8'h56;
                end
            end
        join
        #80 cs_n = 1;
        #240;
        chk8("b2b_miso1", m1, 8'h9A);
        chk8("b2b_miso2", m2, 8'h56);
        chk8("b2b_done_cnt", 8'(done_cnt - d0), 8'd2);
        chk8("b2b_byte_in", spi_byte_in, 8'h34);
    endtask

    task automatic test_abort;
        logic [7:0] m;
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        cs_n = 0;
        #80;
        xfer(8'hFF, 5, m);
        #80 cs_n = 1;
        #240;
        chk8("abort_cnt", 8'(abort_cnt - a0), 8'd1);
        chk8("abort_no_done", 8'(done_cnt - d0), 8'd0);
        chk8("abort_byte_kept", spi_byte_in, 8'h34);
        cs_n = 0;
        #80;
        exp_q.push_back(8'h81);
        xfer(8'h81, 8, m);
        #80 cs_n = 1;
        #240;
        chk8("abort_next_done", 8'(done_cnt - d0), 8'd1);
        chk8("abort_next_byte", spi_byte_in, 8'h81);
        chk8("abort_no_more", 8'(abort_cnt - a0), 8'd1);
    endtask

    task automatic test_reset_mid;
        logic [7:0] m;
        int d0, a0;
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_byte_out = 8'hC3;
        cs_n = 0;
        #80;
        xfer(8'h7E, 4, m);
        #40 rst = 1;
        #40;
        chk8("rstmid_out", {spi_byte_in}, 8'h00);
        chk8("rstmid_flags", {5'd0, frame_active, miso, spi_cycle_done}, 8'h00);
        cs_n = 1;
        #40 rst = 0;
        #200;
        chk8("rstmid_no_pulse", 8'((done_cnt - d0) + (abort_cnt - a0)), 8'd0);
        cs_n = 0;
        #80;
        exp_q.push_back(8'h7E);
        xfer(8'h7E, 8, m);
        #80 cs_n = 1;
        #240;
        chk8("rstmid_byte", spi_byte_in, 8'h7E);
        chk8("rstmid_done", 8'(done_cnt - d0), 8'd1);
        chk8("rstmid_miso", m, 8'hC3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #10;
        test_reset;
        test_basic;
        test_miso;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d bytes never received, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
